// File: rtl/adder_arbiter.sv
// adder_arbiter
//   Shares one external combinational adder between two valid/ready requesters.
//   A round-robin arbiter grants one request at a time. The granted operands are
//   registered onto Add_A/Add_B, and the adder result is captured one cycle later.
//   The captured result is then held on a tagged response port until it is taken.
//   The adder path therefore stays register-to-register.
//
// Parameters
//   WIDTH        operand/sum width (must match the attached adder)
//
// Ports
//   Clk          system clock
//   Reset        asynchronous, active-low reset
//   ReqN_Valid   requester N has operands (N = 0, 1)
//   ReqN_Ready   requester N accepted this cycle
//   ReqN_A/B     requester N operands
//   Add_A/B      registered operands to the adder
//   Add_Sum/Co   adder sum / carry-out (combinational from Add_A/B)
//   Rsp_Valid    result held
//   Rsp_Ready    consumer takes the result
//   Rsp_Id       requester that owns the result
//   Rsp_Sum/Co   registered sum / carry-out
//   Grant_CntN   per-requester saturating grant counts
//
// Configuration
//   ADD_ARB_STATS_EN  when defined, builds the grant counters.
//                     When undefined, Grant_Cnt0/1 are tied to zero.
module adder_arbiter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Req0_Valid,
  output logic             Req0_Ready,
  input  logic [WIDTH-1:0] Req0_A,
  input  logic [WIDTH-1:0] Req0_B,
  input  logic             Req1_Valid,
  output logic             Req1_Ready,
  input  logic [WIDTH-1:0] Req1_A,
  input  logic [WIDTH-1:0] Req1_B,
  output logic [WIDTH-1:0] Add_A,
  output logic [WIDTH-1:0] Add_B,
  input  logic [WIDTH-1:0] Add_Sum,
  input  logic             Add_Co,
  output logic             Rsp_Valid,
  input  logic             Rsp_Ready,
  output logic             Rsp_Id,
  output logic [WIDTH-1:0] Rsp_Sum,
  output logic             Rsp_Co,
  output logic [15:0]      Grant_Cnt0,
  output logic [15:0]      Grant_Cnt1
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   last_grant;
  logic   winner;
  logic   grant;

  // On a tie, the requester that did not win last time gets the grant.
  // With a single valid requester, that requester wins.
  // Ready is gated by Reset so both Ready outputs read low while reset is held.
  always_comb begin
    winner     = (Req0_Valid & Req1_Valid) ? ~last_grant : Req1_Valid;
    grant      = 1'b0;
    state_nxt  = state;
    Req0_Ready = 1'b0;
    Req1_Ready = 1'b0;
    unique case (state)
      IDLE: begin
        if ((Req0_Valid | Req1_Valid) & Reset) begin
          grant      = 1'b1;
          Req0_Ready = ~winner;
          Req1_Ready = winner;
          state_nxt  = CALC;
        end
      end
      CALC: state_nxt = RESP;
      RESP: if (Rsp_Ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign Rsp_Valid = (state == RESP);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      Add_A      <= '0;
      Add_B      <= '0;
      Rsp_Id     <= 1'b0;
      Rsp_Sum    <= '0;
      Rsp_Co     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        last_grant <= winner;
        Rsp_Id     <= winner;
        Add_A      <= winner ? Req1_A : Req0_A;
        Add_B      <= winner ? Req1_B : Req0_B;
      end
      if (state == CALC) begin
        Rsp_Sum <= Add_Sum;
        Rsp_Co  <= Add_Co;
      end
    end
  end

`ifdef ADD_ARB_STATS_EN
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Grant_Cnt0 <= '0;
      Grant_Cnt1 <= '0;
    end else if (grant) begin
      if (winner) begin
        if (Grant_Cnt1 != '1) Grant_Cnt1 <= Grant_Cnt1 + 16'd1;
      end else begin
        if (Grant_Cnt0 != '1) Grant_Cnt0 <= Grant_Cnt0 + 16'd1;
      end
    end
  end
`else
  assign Grant_Cnt0 = '0;
  assign Grant_Cnt1 = '0;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
module tb_adder_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Req0_Valid, Req0_Ready, Req1_Valid, Req1_Ready;
  logic [15:0] Req0_A, Req0_B, Req1_A, Req1_B;
  logic [15:0] Add_A, Add_B, Add_Sum;
  logic        Add_Co;
  logic        Rsp_Valid, Rsp_Ready, Rsp_Id, Rsp_Co;
  logic [15:0] Rsp_Sum;
  logic [15:0] Grant_Cnt0, Grant_Cnt1;

  adder_arbiter #(.WIDTH(16)) dut (
    .Clk(Clk), .Reset(Reset),
    .Req0_Valid(Req0_Valid), .Req0_Ready(Req0_Ready), .Req0_A(Req0_A), .Req0_B(Req0_B),
    .Req1_Valid(Req1_Valid), .Req1_Ready(Req1_Ready), .Req1_A(Req1_A), .Req1_B(Req1_B),
    .Add_A(Add_A), .Add_B(Add_B), .Add_Sum(Add_Sum), .Add_Co(Add_Co),
    .Rsp_Valid(Rsp_Valid), .Rsp_Ready(Rsp_Ready), .Rsp_Id(Rsp_Id),
    .Rsp_Sum(Rsp_Sum), .Rsp_Co(Rsp_Co),
    .Grant_Cnt0(Grant_Cnt0), .Grant_Cnt1(Grant_Cnt1)
  );

  // Attached adder: plain 17-bit addition.
  assign {Add_Co, Add_Sum} = {1'b0, Add_A} + {1'b0, Add_B};

  always #10 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Transaction-level reference: one outstanding operation at most.
  bit          m_busy;
  int          m_age;
  bit          m_last;
  bit          m_id;
  logic [15:0] m_a, m_b, m_sum;
  bit          m_co;
  logic [31:0] m_cnt0, m_cnt1;
  bit          acc0, acc1;
  bit          gq[$];

  // Samples of the DUT taken at the last monitor point.
  logic        s_rdy0, s_rdy1, s_rv, s_id, s_co;
  logic [15:0] s_sum, s_cnt0, s_cnt1;

  // Stimulus controls.
  int pct0 = 0, pct1 = 0;
  bit refill0 = 0, refill1 = 0, rand_rsp = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] rnd16();
    logic [15:0] r;
    case ($urandom_range(0, 5))
      0:       r = 16'hFFFF;
      1:       r = 16'h0000;
      2:       r = 16'h8000;
      default: r = 16'($urandom);
    endcase
    return r;
  endfunction

  task automatic monitor();
    bit          e_rdy0, e_rdy1, e_rv;
    logic [16:0] t;
    s_rdy0 = Req0_Ready; s_rdy1 = Req1_Ready; s_rv = Rsp_Valid;
    s_id = Rsp_Id; s_co = Rsp_Co; s_sum = Rsp_Sum;
    s_cnt0 = Grant_Cnt0; s_cnt1 = Grant_Cnt1;
    if (!Reset) begin
      chk("rst_ready0", 32'(Req0_Ready), 32'd0);
      chk("rst_ready1", 32'(Req1_Ready), 32'd0);
      chk("rst_rsp_valid", 32'(Rsp_Valid), 32'd0);
      m_busy = 0; m_age = 0; m_last = 1; m_cnt0 = 0; m_cnt1 = 0;
      acc0 = 0; acc1 = 0;
      return;
    end
    e_rdy0 = !m_busy && Req0_Valid && (!Req1_Valid || m_last);
    e_rdy1 = !m_busy && Req1_Valid && (!Req0_Valid || !m_last);
    e_rv   = m_busy && (m_age >= 2);
    chk("ready0", 32'(Req0_Ready), 32'(e_rdy0));
    chk("ready1", 32'(Req1_Ready), 32'(e_rdy1));
    chk("rsp_valid", 32'(Rsp_Valid), 32'(e_rv));
    if (m_busy) begin
      chk("add_a", 32'(Add_A), 32'(m_a));
      chk("add_b", 32'(Add_B), 32'(m_b));
    end
    if (e_rv) begin
      chk("rsp_id", 32'(Rsp_Id), 32'(m_id));
      chk("rsp_sum", 32'(Rsp_Sum), 32'(m_sum));
      chk("rsp_co", 32'(Rsp_Co), 32'(m_co));
    end
`ifdef ADD_ARB_STATS_EN
    chk("grant_cnt0", 32'(Grant_Cnt0), m_cnt0);
    chk("grant_cnt1", 32'(Grant_Cnt1), m_cnt1);
`else
    chk("grant_cnt0", 32'(Grant_Cnt0), 32'd0);
    chk("grant_cnt1", 32'(Grant_Cnt1), 32'd0);
`endif
    acc0 = e_rdy0;
    acc1 = e_rdy1;
    if (e_rdy0 || e_rdy1) begin
      m_id   = e_rdy1;
      m_a    = e_rdy1 ? Req1_A : Req0_A;
      m_b    = e_rdy1 ? Req1_B : Req0_B;
      t      = {1'b0, m_a} + {1'b0, m_b};
      m_sum  = t[15:0];
      m_co   = t[16];
      m_last = m_id;
      m_busy = 1;
      m_age  = 1;
      gq.push_back(m_id);
      if (m_id) begin if (m_cnt1 < 65535) m_cnt1++; end
      else      begin if (m_cnt0 < 65535) m_cnt0++; end
    end else if (m_busy) begin
      if (e_rv && Rsp_Ready) m_busy = 0;
      else if (m_age < 2) m_age++;
    end
  endtask

  task automatic drive_update();
    if (acc0) begin
      if (refill0) begin Req0_A = rnd16(); Req0_B = rnd16(); end
      else Req0_Valid = 0;
    end else if (!Req0_Valid && $urandom_range(0, 99) < pct0) begin
      Req0_Valid = 1; Req0_A = rnd16(); Req0_B = rnd16();
    end
    if (acc1) begin
      if (refill1) begin Req1_A = rnd16(); Req1_B = rnd16(); end
      else Req1_Valid = 0;
    end else if (!Req1_Valid && $urandom_range(0, 99) < pct1) begin
      Req1_Valid = 1; Req1_A = rnd16(); Req1_B = rnd16();
    end
    if (rand_rsp) Rsp_Ready = ($urandom_range(0, 99) < 60);
  endtask

  task automatic step();
    @(negedge Clk);
    monitor();
    @(posedge Clk);
    #1;
    drive_update();
  endtask

  task automatic wait_grant(input bit r, input string nm);
    int n = 0;
    do begin step(); n++; end while (!(r ? acc1 : acc0) && n < 60);
    chk({nm, "_granted"}, 32'(r ? acc1 : acc0), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while ((m_busy || Req0_Valid || Req1_Valid) && n < 300) begin step(); n++; end
    chk("drain_timeout", 32'(m_busy || Req0_Valid || Req1_Valid), 32'd0);
  endtask

  task automatic request(input bit r, input logic [15:0] a, input logic [15:0] b);
    if (r) begin Req1_Valid = 1; Req1_A = a; Req1_B = b; end
    else   begin Req0_Valid = 1; Req0_A = a; Req0_B = b; end
  endtask

  initial begin
    logic [15:0] held;
    Reset = 0; Rsp_Ready = 0;
    Req0_Valid = 0; Req0_A = '0; Req0_B = '0;
    Req1_Valid = 0; Req1_A = '0; Req1_B = '0;
    #5;
    chk("reset_add_a", 32'(Add_A), 32'd0);
    chk("reset_add_b", 32'(Add_B), 32'd0);
    chk("reset_rsp_valid", 32'(Rsp_Valid), 32'd0);
    chk("reset_rsp_sum", 32'(Rsp_Sum), 32'd0);
    chk("reset_rsp_id", 32'(Rsp_Id), 32'd0);
    chk("reset_cnt0", 32'(Grant_Cnt0), 32'd0);
    step(); step();
    Reset = 1;
    step();

    // Single request from requester 0.
    Rsp_Ready = 1;
    request(0, 16'h1234, 16'h4321);
    wait_grant(0, "single");
    chk("single_ready0", 32'(s_rdy0), 32'd1);
    chk("single_ready1", 32'(s_rdy1), 32'd0);
    step();
    chk("single_calc_no_rsp", 32'(s_rv), 32'd0);
    chk("single_ready0_once", 32'(s_rdy0), 32'd0);
    step();
    chk("single_rsp_valid", 32'(s_rv), 32'd1);
    chk("single_sum", 32'(s_sum), 32'h5555);
    chk("single_co", 32'(s_co), 32'd0);
    chk("single_id", 32'(s_id), 32'd0);
    drain();

    // Carry-out from requester 1.
    request(1, 16'hFFFF, 16'h0001);
    wait_grant(1, "carry");
    step(); step();
    chk("carry_rsp_valid", 32'(s_rv), 32'd1);
    chk("carry_sum", 32'(s_sum), 32'h0000);
    chk("carry_co", 32'(s_co), 32'd1);
    chk("carry_id", 32'(s_id), 32'd1);
    drain();

    // Contention: both valid continuously.
    gq.delete();
    refill0 = 1; refill1 = 1;
    request(0, 16'h1111, 16'h0F0F);
    request(1, 16'hA000, 16'h7777);
    begin
      int n = 0;
      while (gq.size() < 6 && n < 100) begin step(); n++; end
    end
    refill0 = 0; refill1 = 0;
    drain();
    chk("contention_count", 32'(gq.size() >= 6), 32'd1);
    for (int i = 0; i < 6; i++)
      chk($sformatf("contention_grant%0d", i), 32'(gq[i]), 32'(i % 2));

    // Backpressure with requester 1 waiting.
    Rsp_Ready = 0;
    request(0, 16'h00FF, 16'h0F00);
    wait_grant(0, "bp_first");
    request(1, 16'h2222, 16'h3333);
    step(); step();
    held = s_sum;
    chk("bp_held_sum", 32'(held), 32'h0FFF);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_rsp_valid", 32'(s_rv), 32'd1);
      chk("bp_sum_stable", 32'(s_sum), 32'(held));
      chk("bp_ready1_low", 32'(s_rdy1), 32'd0);
    end
    Rsp_Ready = 1;
    step();
    chk("bp_release_ready1", 32'(s_rdy1), 32'd0);
    step();
    chk("bp_grant_next", 32'(s_rdy1), 32'd1);
    drain();

    // Reset in the middle of CALC.
    request(0, 16'h4000, 16'h0004);
    wait_grant(0, "rstcalc");
    Reset = 0;
    #1;
    chk("rstcalc_add_a", 32'(Add_A), 32'd0);
    chk("rstcalc_add_b", 32'(Add_B), 32'd0);
    chk("rstcalc_rsp_valid", 32'(Rsp_Valid), 32'd0);
    chk("rstcalc_rsp_sum", 32'(Rsp_Sum), 32'd0);
    chk("rstcalc_rsp_co", 32'(Rsp_Co), 32'd0);
    chk("rstcalc_rsp_id", 32'(Rsp_Id), 32'd0);
    chk("rstcalc_ready0", 32'(Req0_Ready), 32'd0);
    chk("rstcalc_cnt0", 32'(Grant_Cnt0), 32'd0);
    step(); step();
    Reset = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rstcalc_no_rsp", 32'(s_rv), 32'd0);
    end
    request(1, 16'h0102, 16'h0304);
    wait_grant(1, "rstcalc_next");
    step(); step();
    chk("rstcalc_next_sum", 32'(s_sum), 32'h0406);
    chk("rstcalc_next_id", 32'(s_id), 32'd1);
    drain();

    // Stats: 3 grants to requester 0 and 2 to requester 1 after a reset.
    Reset = 0;
    step(); step();
    Reset = 1;
    for (int i = 0; i < 3; i++) begin
      request(0, 16'(i), 16'h0010);
      wait_grant(0, "stats0");
      drain();
    end
    for (int i = 0; i < 2; i++) begin
      request(1, 16'(i), 16'h0020);
      wait_grant(1, "stats1");
      drain();
    end
    step();
`ifdef ADD_ARB_STATS_EN
    chk("stats_cnt0", 32'(s_cnt0), 32'd3);
    chk("stats_cnt1", 32'(s_cnt1), 32'd2);
`else
    chk("stats_cnt0", 32'(s_cnt0), 32'd0);
    chk("stats_cnt1", 32'(s_cnt1), 32'd0);
`endif

    // Randomized traffic with random backpressure.
    pct0 = 40; pct1 = 40; rand_rsp = 1;
    repeat (400) step();
    pct0 = 0; pct1 = 0; rand_rsp = 0; Rsp_Ready = 1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
